// File: rtl/rs_syndrome_calc_if.sv
// Codeword byte stream in, syndrome results out, for rs_syndrome_calc.
// With RS_SYN_ERR_CNT_EN defined the bundle also carries the 16-bit err_cnt.
interface rs_syndrome_calc_if #(
  parameter int unsigned NPAR = 8
);
  logic                din_val;
  logic                din_sop;
  logic                din_eop;
  logic [7:0]          din;
  logic                syn_val;
  logic [8*NPAR-1:0]   syn;
  logic                syn_nz;
  logic                len_err;
  logic                busy;
`ifdef RS_SYN_ERR_CNT_EN
  logic [15:0]         err_cnt;

  modport master (
    output din_val, din_sop, din_eop, din,
    input  syn_val, syn, syn_nz, len_err, busy, err_cnt
  );
  modport slave (
    input  din_val, din_sop, din_eop, din,
    output syn_val, syn, syn_nz, len_err, busy, err_cnt
  );
`else
  modport master (
    output din_val, din_sop, din_eop, din,
    input  syn_val, syn, syn_nz, len_err, busy
  );
  modport slave (
    input  din_val, din_sop, din_eop, din,
    output syn_val, syn, syn_nz, len_err, busy
  );
`endif
endinterface

// File: rtl/rs_syndrome_calc.sv
// RS(NN,KK) syndrome calculator over GF(2^8) (poly 0x11D), Horner evaluation per root.
// Optional RS_SYN_ERR_CNT_EN adds a saturating count of frames with errors.
module rs_syndrome_calc #(
  parameter int unsigned NN        = 255,
  parameter int unsigned KK        = 247,
  parameter int unsigned NPAR      = NN - KK,
  parameter int unsigned GEN_START = 0
) (
  input logic               clk,
  input logic               rst,
  rs_syndrome_calc_if.slave bus
);

  localparam logic [8:0] NnCnt = 9'(NN);

  typedef enum logic [0:0] {StIdle, StAcc} state_e;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] alpha_pow(input int unsigned e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 255; i++) begin
      if (i < int'(e % 255)) r = gf_mul(r, 8'h02);
    end
    return r;
  endfunction

  state_e            state;
  logic [8:0]        count;
  logic [8*NPAR-1:0] acc;
  logic [8*NPAR-1:0] acc_upd;
  logic [8*NPAR-1:0] term_syn;
  logic [8:0]        cnt_inc;
  logic              load;
  logic              step;
  logic              term;
  logic              term_len_err;

  logic              syn_val;
  logic [8*NPAR-1:0] syn;
  logic              syn_nz;
  logic              len_err;

  // Multiplying by a constant root folds down to a fixed XOR network.
  for (genvar j = 0; j < int'(NPAR); j++) begin : g_root
    localparam logic [7:0] Root = alpha_pow(GEN_START + j);
    assign acc_upd[8*j +: 8] = gf_mul(acc[8*j +: 8], Root) ^ bus.din;
  end

  always_comb begin
    load    = bus.din_val && bus.din_sop;
    step    = bus.din_val && !bus.din_sop && (state == StAcc);
    cnt_inc = count + 9'd1;
    // A frame ends on eop or on the first beat that pushes the count past NN.
    term    = (load && bus.din_eop) || (step && (bus.din_eop || (cnt_inc > NnCnt)));
    term_syn     = load ? {NPAR{bus.din}} : acc_upd;
    term_len_err = (load ? 9'd1 : cnt_inc) != NnCnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= StIdle;
      count   <= '0;
      acc     <= '0;
      syn_val <= 1'b0;
      syn     <= '0;
      syn_nz  <= 1'b0;
      len_err <= 1'b0;
    end else begin
      syn_val <= term;
      if (term) begin
        syn     <= term_syn;
        syn_nz  <= |term_syn;
        len_err <= term_len_err;
      end
      if (load) begin
        acc   <= {NPAR{bus.din}};
        count <= 9'd1;
      end else if (step) begin
        acc   <= acc_upd;
        count <= cnt_inc;
      end
      if (term) begin
        state <= StIdle;
      end else if (load) begin
        state <= StAcc;
      end
    end
  end

`ifdef RS_SYN_ERR_CNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (term && ((|term_syn) || term_len_err) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  assign bus.err_cnt = err_cnt;
`endif

  assign bus.syn_val = syn_val;
  assign bus.syn     = syn;
  assign bus.syn_nz  = syn_nz;
  assign bus.len_err = len_err;
  assign bus.busy    = (state == StAcc);

endmodule
